// File: rtl/ac_pkg.sv
// ---------------------------------------------------------------------------
// ac_pkg -- shared types and constants for the access-control frame datapath.
//
// Contents:
//   state_t          frame controller state (IDLE, RUN, DONE)
//   DIM_WIDTH_DEF    default width of the runtime dimensions and counters
//   STALL_CNT_WIDTH  width of the optional output-stall counter
// ---------------------------------------------------------------------------
package ac_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DIM_WIDTH_DEF   = 16;
    localparam int STALL_CNT_WIDTH = 32;

endpackage

// File: rtl/ac_sync_fifo.sv
// ---------------------------------------------------------------------------
// ac_sync_fifo -- single-clock FIFO with a registered head word.
//
// The head of the queue is held in rd_data, a flop that is reloaded every
// cycle with the entry that will be at the head after this cycle's push/pop,
// so a word written in cycle N is visible at rd_data in cycle N+1.
// Pointers carry one extra bit so that full and empty can be told apart when
// the address bits match.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clr          synchronous flush (pointers to zero)
//   push         write push_data; ignored when full
//   push_data    word to write
//   pop          drop the head word; ignored when empty
//   rd_data      registered head word (valid while !empty)
//   full, empty  occupancy flags
// ---------------------------------------------------------------------------
module ac_sync_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      rd_ptr_nxt;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign rd_ptr_nxt = rd_ptr + {{AW{1'b0}}, do_pop};

    // NOTE: sequential state is assigned with <= so every flop samples the
    // values from before the clock edge, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            rd_ptr <= rd_ptr_nxt;
        end
    end

    // NOTE: the storage array has no reset; only the pointers define which
    // entries are meaningful, and leaving it unreset lets it map to RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    // Head register: when the slot that becomes the head is being written in
    // this same cycle (queue empty after the pop), forward the incoming word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (clr) begin
            rd_data <= '0;
        end else if (do_push && (wr_ptr == rd_ptr_nxt)) begin
            rd_data <= push_data;
        end else begin
            rd_data <= mem[rd_ptr_nxt[AW-1:0]];
        end
    end

endmodule

// File: rtl/ac_stream_frame_ctrl.sv
// ---------------------------------------------------------------------------
// ac_stream_frame_ctrl -- access-control datapath between the AXI-Stream DMA
// and the bicubic upsampler.
//
// Input path : s_axis pixels pass combinationally to the upsampler read port
//              while a frame is running.
// Output path: upsampler pixels are buffered in ac_sync_fifo and re-framed
//              onto m_axis; tuser marks the first pixel of the frame, tlast
//              the last pixel of each line. The frame size is latched from
//              cfg_dst_w/cfg_dst_h on an accepted cfg_start.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   cfg_start, cfg_dst_w, cfg_dst_h  frame start pulse and dimensions
//   s_axis_*                         source stream (slave)
//   ac_upsp_r*, upsp_ac_rready       pixels to the upsampler
//   upsp_ac_w*, ac_upsp_wready       pixels from the upsampler
//   m_axis_*                         output stream (master)
//   busy, done                       frame in progress / end-of-frame pulse
//   stall_cnt                        only with ACCTL_STALL_CNT_EN: RUN cycles
//                                    with m_axis_tvalid && !m_axis_tready
//
// Build option: define ACCTL_STALL_CNT_EN to add the stall_cnt port.
// ---------------------------------------------------------------------------
module ac_stream_frame_ctrl
    import ac_pkg::*;
#(
    parameter int AXIS_DATA_WIDTH = 24,
    parameter int UPSP_DATA_WIDTH = 24,
    parameter int DIM_WIDTH       = DIM_WIDTH_DEF,
    parameter int FIFO_DEPTH      = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cfg_start,
    input  logic [DIM_WIDTH-1:0]       cfg_dst_w,
    input  logic [DIM_WIDTH-1:0]       cfg_dst_h,
    input  logic                       s_axis_tvalid,
    input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
    output logic                       s_axis_tready,
    output logic                       ac_upsp_rvalid,
    output logic [UPSP_DATA_WIDTH-1:0] ac_upsp_rdata,
    input  logic                       upsp_ac_rready,
    input  logic                       upsp_ac_wvalid,
    input  logic [UPSP_DATA_WIDTH-1:0] upsp_ac_wdata,
    output logic                       ac_upsp_wready,
    output logic                       m_axis_tvalid,
    output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata,
    output logic                       m_axis_tlast,
    output logic                       m_axis_tuser,
    input  logic                       m_axis_tready,
    output logic                       busy,
`ifdef ACCTL_STALL_CNT_EN
    output logic                       done,
    output logic [STALL_CNT_WIDTH-1:0] stall_cnt
`else
    output logic                       done
`endif
);

    localparam logic [DIM_WIDTH-1:0] DIM_ONE = DIM_WIDTH'(1);

    state_t               state_q;
    state_t               state_d;
    logic [DIM_WIDTH-1:0] w_q;
    logic [DIM_WIDTH-1:0] h_q;
    logic [DIM_WIDTH-1:0] col_q;
    logic [DIM_WIDTH-1:0] row_q;
    logic [DIM_WIDTH-1:0] w_m1;
    logic [DIM_WIDTH-1:0] h_m1;
    logic                 in_run;
    logic                 start_acc;
    logic                 last_col;
    logic                 last_row;
    logic                 m_hs;
    logic                 fifo_push;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [UPSP_DATA_WIDTH-1:0] fifo_rd_data;

    assign in_run = (state_q == RUN);

    // A start is taken only from IDLE and only with a non-empty frame.
    assign start_acc = (state_q == IDLE) && cfg_start &&
                       (cfg_dst_w != '0) && (cfg_dst_h != '0);

    // ---- input path: zero-latency pass-through while running --------------
    assign ac_upsp_rvalid = in_run && s_axis_tvalid;
    assign ac_upsp_rdata  = in_run ? s_axis_tdata : '0;
    assign s_axis_tready  = in_run && upsp_ac_rready;

    // ---- output path -------------------------------------------------------
    assign ac_upsp_wready = in_run && !fifo_full;
    assign fifo_push      = upsp_ac_wvalid && ac_upsp_wready;
    assign m_axis_tvalid  = in_run && !fifo_empty;
    assign m_hs           = m_axis_tvalid && m_axis_tready;
    assign m_axis_tdata   = fifo_rd_data;

    ac_sync_fifo #(
        .WIDTH (UPSP_DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (start_acc),
        .push      (fifo_push),
        .push_data (upsp_ac_wdata),
        .pop       (m_hs),
        .rd_data   (fifo_rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // ---- frame position ----------------------------------------------------
    assign w_m1     = w_q - DIM_ONE;
    assign h_m1     = h_q - DIM_ONE;
    assign last_col = (col_q == w_m1);
    assign last_row = (row_q == h_m1);

    // Sidebands are qualified by tvalid so they read 0 whenever no beat is up.
    assign m_axis_tlast = m_axis_tvalid && last_col;
    assign m_axis_tuser = m_axis_tvalid && (col_q == '0) && (row_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_q   <= '0;
            h_q   <= '0;
            col_q <= '0;
            row_q <= '0;
        end else if (start_acc) begin
            w_q   <= cfg_dst_w;
            h_q   <= cfg_dst_h;
            col_q <= '0;
            row_q <= '0;
        end else if (m_hs) begin
            if (last_col) begin
                col_q <= '0;
                row_q <= last_row ? '0 : row_q + DIM_ONE;
            end else begin
                col_q <= col_q + DIM_ONE;
            end
        end
    end

    // ---- control FSM -------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // NOTE: state_d gets its default before the case so every path assigns
    // it and no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_acc) state_d = RUN;
            RUN:     if (m_hs && last_col && last_row) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);

`ifdef ACCTL_STALL_CNT_EN
    // ---- output stall counter (saturating) --------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (start_acc) begin
            stall_cnt <= '0;
        end else if (m_axis_tvalid && !m_axis_tready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + STALL_CNT_WIDTH'(1);
        end
    end
`endif

endmodule

// File: tb/tb_ac_stream_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ac_stream_frame_ctrl -- directed bench for ac_stream_frame_ctrl, built
// with FIFO_DEPTH=4. The stall counter steps run only when the design is
// built with ACCTL_STALL_CNT_EN.
// ---------------------------------------------------------------------------
module tb_ac_stream_frame_ctrl;

    localparam int DW   = 24;
    localparam int DIMW = 16;

    logic            clk;
    logic            rst_n;
    logic            cfg_start;
    logic [DIMW-1:0] cfg_dst_w;
    logic [DIMW-1:0] cfg_dst_h;
    logic            s_axis_tvalid;
    logic [DW-1:0]   s_axis_tdata;
    logic            s_axis_tready;
    logic            ac_upsp_rvalid;
    logic [DW-1:0]   ac_upsp_rdata;
    logic            upsp_ac_rready;
    logic            upsp_ac_wvalid;
    logic [DW-1:0]   upsp_ac_wdata;
    logic            ac_upsp_wready;
    logic            m_axis_tvalid;
    logic [DW-1:0]   m_axis_tdata;
    logic            m_axis_tlast;
    logic            m_axis_tuser;
    logic            m_axis_tready;
    logic            busy;
    logic            done;
`ifdef ACCTL_STALL_CNT_EN
    logic [31:0]     stall_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    ac_stream_frame_ctrl #(
        .AXIS_DATA_WIDTH (DW),
        .UPSP_DATA_WIDTH (DW),
        .DIM_WIDTH       (DIMW),
        .FIFO_DEPTH      (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cfg_start      (cfg_start),
        .cfg_dst_w      (cfg_dst_w),
        .cfg_dst_h      (cfg_dst_h),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tready  (s_axis_tready),
        .ac_upsp_rvalid (ac_upsp_rvalid),
        .ac_upsp_rdata  (ac_upsp_rdata),
        .upsp_ac_rready (upsp_ac_rready),
        .upsp_ac_wvalid (upsp_ac_wvalid),
        .upsp_ac_wdata  (upsp_ac_wdata),
        .ac_upsp_wready (ac_upsp_wready),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tlast   (m_axis_tlast),
        .m_axis_tuser   (m_axis_tuser),
        .m_axis_tready  (m_axis_tready),
        .busy           (busy),
`ifdef ACCTL_STALL_CNT_EN
        .done           (done),
        .stall_cnt      (stall_cnt)
`else
        .done           (done)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input int w, input int h);
        cfg_dst_w = DIMW'(w);
        cfg_dst_h = DIMW'(h);
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
    endtask

    // Feed the remaining upsampler pixels (base+pushed0 onward) with the sink
    // always ready, check every beat from index beat0 to the end of the frame,
    // then check the done pulse and the fall of busy.
    task automatic run_frame(input int w, input int h, input logic [DW-1:0] base,
                             input int pushed0, input int beat0);
        int pushed;
        int beat;
        int cyc;
        int n;
        pushed = pushed0;
        beat   = beat0;
        cyc    = 0;
        n      = w * h;
        m_axis_tready = 1'b1;
        while (beat < n && cyc < 200) begin
            upsp_ac_wvalid = (pushed < n);
            upsp_ac_wdata  = base + DW'(pushed);
            #1;
            if (m_axis_tvalid) begin
                check("beat_data",  32'(m_axis_tdata), 32'(base + DW'(beat)));
                check("beat_tuser", 32'(m_axis_tuser), 32'(beat == 0));
                check("beat_tlast", 32'(m_axis_tlast), 32'((beat % w) == (w - 1)));
                beat++;
            end
            if (upsp_ac_wvalid && ac_upsp_wready) pushed++;
            cyc++;
            tick();
        end
        upsp_ac_wvalid = 1'b0;
        check("frame_beats",  32'(beat), 32'(n));
        check("done_pulse",   32'(done), 32'd1);
        check("busy_in_done", 32'(busy), 32'd1);
        check("tvalid_done",  32'(m_axis_tvalid), 32'd0);
        tick();
        check("done_clear", 32'(done), 32'd0);
        check("busy_fall",  32'(busy), 32'd0);
    endtask

    initial begin
        rst_n          = 1'b0;
        cfg_start      = 1'b0;
        cfg_dst_w      = '0;
        cfg_dst_h      = '0;
        s_axis_tvalid  = 1'b0;
        s_axis_tdata   = '0;
        upsp_ac_rready = 1'b0;
        upsp_ac_wvalid = 1'b0;
        upsp_ac_wdata  = '0;
        m_axis_tready  = 1'b0;

        // ---- reset state ----
        #2;
        check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("rst_tdata",  32'(m_axis_tdata),  32'd0);
        check("rst_tuser",  32'(m_axis_tuser),  32'd0);
        check("rst_tlast",  32'(m_axis_tlast),  32'd0);
        check("rst_busy",   32'(busy),          32'd0);
        check("rst_done",   32'(done),          32'd0);
        check("rst_wready", 32'(ac_upsp_wready), 32'd0);
        #11 rst_n = 1'b1;
        tick();

        // ---- 1: 4x2 frame, sink always ready ----
        check("idle_wready", 32'(ac_upsp_wready), 32'd0);
        start_frame(4, 2);
        check("t1_busy", 32'(busy), 32'd1);
        run_frame(4, 2, 24'h100000, 0, 0);
        upsp_ac_wvalid = 1'b1;
        #1;
        check("surplus_wready", 32'(ac_upsp_wready), 32'd0);
        upsp_ac_wvalid = 1'b0;
        tick();

        // ---- 3: input pass-through (gated in IDLE, live in RUN) ----
        s_axis_tvalid  = 1'b1;
        s_axis_tdata   = 24'hA5A5A5;
        upsp_ac_rready = 1'b1;
        #1;
        check("idle_s_tready", 32'(s_axis_tready),  32'd0);
        check("idle_rvalid",   32'(ac_upsp_rvalid), 32'd0);

        // ---- 2: 3x2 frame, FIFO fills with sink stalled, then drains ----
        start_frame(3, 2);
        upsp_ac_rready = 1'b0;
        #1;
        check("pt_s_tready0", 32'(s_axis_tready),  32'd0);
        check("pt_rvalid",    32'(ac_upsp_rvalid), 32'd1);
        check("pt_rdata",     32'(ac_upsp_rdata),  32'hA5A5A5);
        upsp_ac_rready = 1'b1;
        #1;
        check("pt_s_tready1", 32'(s_axis_tready),  32'd1);
        check("pt_rdata2",    32'(ac_upsp_rdata),  32'hA5A5A5);
        s_axis_tvalid  = 1'b0;
        upsp_ac_rready = 1'b0;

        m_axis_tready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            upsp_ac_wvalid = 1'b1;
            upsp_ac_wdata  = 24'h200000 + DW'(i);
            #1;
            check("fill_wready", 32'(ac_upsp_wready), 32'd1);
            tick();
        end
        upsp_ac_wdata = 24'h200004;
        #1;
        check("full_wready",  32'(ac_upsp_wready), 32'd0);
        check("full_tvalid",  32'(m_axis_tvalid),  32'd1);
        check("full_tdata",   32'(m_axis_tdata),   32'h200000);
        check("full_tuser",   32'(m_axis_tuser),   32'd1);
        tick();
        check("stall_wready", 32'(ac_upsp_wready), 32'd0);
        check("stall_tdata",  32'(m_axis_tdata),   32'h200000);
        check("stall_tuser",  32'(m_axis_tuser),   32'd1);
        run_frame(3, 2, 24'h200000, 4, 0);

        // ---- 4: zero-width start ignored, then a 2x1 frame ----
        start_frame(0, 5);
        check("zero_busy", 32'(busy), 32'd0);
        tick();
        check("zero_done", 32'(done), 32'd0);
        check("zero_busy2", 32'(busy), 32'd0);
        start_frame(2, 1);
        check("t4_busy", 32'(busy), 32'd1);
        run_frame(2, 1, 24'h300000, 0, 0);

        // ---- 5: reset after 3 beats of a 4x4 frame ----
        start_frame(4, 4);
        m_axis_tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            upsp_ac_wvalid = 1'b1;
            upsp_ac_wdata  = 24'h400000 + DW'(i);
            tick();
        end
        upsp_ac_wvalid = 1'b0;
        m_axis_tready  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("pre_rst_tdata", 32'(m_axis_tdata), 32'h400000 + 32'(i));
            tick();
        end
        m_axis_tready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_tvalid", 32'(m_axis_tvalid),  32'd0);
        check("mid_rst_tdata",  32'(m_axis_tdata),   32'd0);
        check("mid_rst_tuser",  32'(m_axis_tuser),   32'd0);
        check("mid_rst_tlast",  32'(m_axis_tlast),   32'd0);
        check("mid_rst_busy",   32'(busy),           32'd0);
        check("mid_rst_done",   32'(done),           32'd0);
        check("mid_rst_wready", 32'(ac_upsp_wready), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        start_frame(4, 4);
        run_frame(4, 4, 24'h500000, 0, 0);

`ifdef ACCTL_STALL_CNT_EN
        // ---- 6: stall counter, ignored restart, clear on accepted start ----
        start_frame(4, 2);
        check("sc_clear0", stall_cnt, 32'd0);
        m_axis_tready  = 1'b0;
        upsp_ac_wvalid = 1'b1;
        upsp_ac_wdata  = 24'h600000;
        tick();
        upsp_ac_wvalid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i == 4) begin
                cfg_dst_w = 16'd1;
                cfg_dst_h = 16'd1;
                cfg_start = 1'b1;
            end
            tick();
            cfg_start = 1'b0;
        end
        check("sc_ten",  stall_cnt, 32'd10);
        check("sc_busy", 32'(busy), 32'd1);
        run_frame(4, 2, 24'h600000, 1, 0);
        check("sc_hold", stall_cnt, 32'd10);
        start_frame(2, 2);
        check("sc_cleared", stall_cnt, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ac_stream_frame_ctrl.md
Name: ac_stream_frame_ctrl

Overview:
- Next-generation access-control datapath between the AXI-Stream DMA and the bicubic upsampler.
- Input path: forwards source pixels from the slave stream to the upsampler read port.
- Output path: buffers upsampler output in a parametrised FIFO and re-frames it onto the master stream.
  - tuser marks start of frame; tlast marks end of line.
- Generalised over the fixed-size predecessor: frame size is set at run time, FIFO depth is a parameter, and done/busy status is produced here.

Parameters:
AXIS_DATA_WIDTH, 24, stream pixel width; must equal UPSP_DATA_WIDTH.
UPSP_DATA_WIDTH, 24, upsampler pixel width.
DIM_WIDTH, 16, width of the runtime dimension inputs and the row/column counters.
FIFO_DEPTH, 8, output FIFO entries; power of two, at least 2.

Ports:
clk  in  1  single clock.
rst_n  in  1  asynchronous active-low reset.
cfg_start  in  1  single-cycle start pulse.
cfg_dst_w  in  DIM_WIDTH  destination width in pixels.
cfg_dst_h  in  DIM_WIDTH  destination height in lines.
s_axis_tvalid  in  1  source pixel valid.
s_axis_tdata  in  AXIS_DATA_WIDTH  source pixel.
s_axis_tready  out  1  source ready.
ac_upsp_rvalid  out  1  pixel valid to upsampler.
ac_upsp_rdata  out  UPSP_DATA_WIDTH  pixel to upsampler.
upsp_ac_rready  in  1  upsampler ready.
upsp_ac_wvalid  in  1  upsampled pixel valid.
upsp_ac_wdata  in  UPSP_DATA_WIDTH  upsampled pixel.
ac_upsp_wready  out  1  FIFO can accept.
m_axis_tvalid  out  1  output valid.
m_axis_tdata  out  AXIS_DATA_WIDTH  output pixel.
m_axis_tlast  out  1  last pixel of a line.
m_axis_tuser  out  1  first pixel of a frame.
m_axis_tready  in  1  downstream ready.
busy  out  1  frame in progress.
done  out  1  one-cycle end-of-frame pulse.

Behaviour:
- Reset: all outputs are 0; FIFO is emptied; counters are 0; state is IDLE.
- States: IDLE, RUN, DONE.
- IDLE:
  - s_axis_tready=0 and ac_upsp_wready=0.
  - On cfg_start: latch cfg_dst_w and cfg_dst_h, clear counters, go to RUN.
  - If either latched dimension is 0, cfg_start is ignored and the block stays in IDLE.
- RUN, input path:
  - Combinational pass-through: ac_upsp_rvalid=s_axis_tvalid, ac_upsp_rdata=s_axis_tdata, s_axis_tready=upsp_ac_rready.
  - Zero latency.
  - Outside RUN, ac_upsp_rvalid=0 and s_axis_tready=0.
- RUN, output path:
  - ac_upsp_wready = !fifo_full.
  - A push at full is never offered, so simultaneous push and pop at full cannot overflow.
  - Push and pop in the same cycle at non-full/non-empty leaves the occupancy unchanged.
  - FIFO output is registered: a word written in cycle N can appear on m_axis in cycle N+1.
  - m_axis_tvalid = !fifo_empty.
  - m_axis data and sideband stay stable while tvalid is high and tready is low.
- Counters:
  - col and row advance only on an m_axis handshake.
  - col wraps to 0 at w-1, at which point row increments.
  - m_axis_tlast = (col==w-1).
  - m_axis_tuser = (col==0 && row==0).
- The handshake with col==w-1 and row==h-1 moves the block to DONE.
  - Surplus upsampler writes after that point are refused (wready=0 outside RUN).
- DONE: done=1 for exactly one cycle, then IDLE. busy = (state != IDLE).
- cfg_start while busy is ignored; the latched dimensions are unchanged.
- Reset mid-frame: immediate return to reset values, FIFO contents discarded, the next frame starts with tuser.
- Arithmetic: counter compares use w-1 and h-1 computed in DIM_WIDTH bits; no wider arithmetic.

Optional Feature:
- Macro: ACCTL_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt [31:0].
  - Counts RUN cycles with m_axis_tvalid && !m_axis_tready.
  - Cleared on an accepted cfg_start; saturates at all-ones; holds its value in IDLE.
- Undefined: the port and its logic are absent; behaviour is otherwise identical.

Decomposition:
- Package ac_pkg:
  - state enum (IDLE, RUN, DONE);
  - DIM_WIDTH default constant;
  - STALL_CNT_WIDTH = 32.
- Sub-module ac_sync_fifo:
  - parametrised WIDTH and DEPTH;
  - registered output;
  - full/empty flags;
  - pointers one bit wider than log2(DEPTH) for wrap detection.

Test Plan:
1. w=4, h=2, start; upsampler writes 8 pixels; m_tready=1 -> 8 beats in order; tuser on beat 1; tlast on beats 4 and 8; done pulses the cycle after beat 8; busy falls with done.
2. FIFO_DEPTH=4, m_tready=0, upsampler offers 6 pixels -> wready drops after 4 accepted; release tready -> all 6 delivered in order; no loss or duplicate.
3. In RUN, hold upsp_ac_rready=0 then 1 -> s_axis_tready follows in the same cycle; data 0xA5A5A5 appears unchanged on ac_upsp_rdata.
4. cfg_start with w=0, h=5 -> busy stays 0, no done; then w=2, h=1 -> a normal 2-beat frame with tlast on beat 2.
5. Reset asserted after 3 beats of a 4x4 frame -> all outputs 0 asynchronously; a new start gives tuser on the first beat and a full 16-beat frame.
6. ACCTL_STALL_CNT_EN defined, 10 stalled cycles mid-frame -> stall_cnt=10; a second cfg_start while busy is ignored; the next accepted start clears stall_cnt to 0.
